lm32_ram_fifo: RTL and testbench

Single-clock show-ahead FIFO built around one `lm32_ram` pseudo dual-port RAM instance. It sits directly upstream of the RAM and owns all of the RAM's address, enable and write controls. Producers and consumers see valid/ready handshakes, with the head word always presented combinationally. Fill level, programmable thresholds and a sticky overflow flag are provided for bus bridges and debug buffers.

---
 rtl/lm32_ram_fifo_pkg.sv | 7 +
 rtl/lm32_ram_fifo_ram.sv | 45 ++++
 rtl/lm32_ram_fifo.sv | 103 ++++++++++
 tb/tb_lm32_ram_fifo.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/lm32_ram_fifo_pkg.sv
// Shared constants for the lm32 RAM-backed FIFO slice.
package lm32_ram_fifo_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

endpackage

// File: rtl/lm32_ram_fifo_ram.sv
// lm32_ram: pseudo dual-port RAM with a registered read address and an
// asynchronous array read, so a word written on one edge is visible after it.
module lm32_ram
  import lm32_ram_fifo_pkg::*;
#(
  parameter int data_width    = 32,
  parameter int address_width = 4
) (
  input  logic                     read_clk,
  input  logic                     write_clk,
  input  logic                     reset,
  input  logic                     enable_read,
  input  logic [address_width-1:0] read_address,
  input  logic                     enable_write,
  input  logic [address_width-1:0] write_address,
  input  logic [data_width-1:0]    write_data,
  input  logic                     write_enable,
  output logic [data_width-1:0]    read_data
);

  localparam int DEPTH = 1 << address_width;

  logic [data_width-1:0]    mem_q [0:DEPTH-1];
  logic [address_width-1:0] ra_q;
  logic                     we;

  // Writes are blocked while reset is held so no stray word lands mid-reset.
  assign we = (enable_write == TRUE) && (write_enable == TRUE) && !reset;

  always_ff @(posedge write_clk) begin
    if (we) begin
      mem_q[write_address] <= write_data;
    end
  end

  // Read address register is deliberately left unreset.
  always_ff @(posedge read_clk) begin
    if (enable_read) begin
      ra_q <= read_address;
    end
  end

  assign read_data = mem_q[ra_q];

endmodule

// File: rtl/lm32_ram_fifo.sv
// Show-ahead single-clock FIFO over one lm32_ram; owns all RAM controls and
// provides level, registered almost-full/empty thresholds and sticky overflow.
module lm32_ram_fifo
  import lm32_ram_fifo_pkg::*;
#(
  parameter int data_width         = 32,
  parameter int address_width      = 4,
  parameter int almost_full_level  = 12,
  parameter int almost_empty_level = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   push_valid_i,
  output logic                   push_ready_o,
  input  logic [data_width-1:0]  push_data_i,
  output logic                   pop_valid_o,
  input  logic                   pop_ready_i,
  output logic [data_width-1:0]  pop_data_o,
  output logic [address_width:0] level_o,
  output logic                   almost_full_o,
  output logic                   almost_empty_o,
  output logic                   overflow_o
);

  localparam int PTR_W = address_width + 1;
  localparam logic [PTR_W-1:0] AF_LVL = PTR_W'(almost_full_level);
  localparam logic [PTR_W-1:0] AE_LVL = PTR_W'(almost_empty_level);

  // Valid/ready: a transfer happens on a rising edge where valid and ready
  // are both high; ready never depends on the valid of the same side.
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] level_d;
  logic             overflow_q, overflow_d;
  logic             almost_full_q, almost_full_d;
  logic             almost_empty_q, almost_empty_d;
  logic             empty, full, push, pop, ram_we;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[address_width-1:0] == rd_ptr_q[address_width-1:0]) &&
                 (wr_ptr_q[address_width] != rd_ptr_q[address_width]);

  assign push_ready_o   = !full;
  assign pop_valid_o    = !empty;
  assign level_o        = wr_ptr_q - rd_ptr_q;
  assign almost_full_o  = almost_full_q;
  assign almost_empty_o = almost_empty_q;
  assign overflow_o     = overflow_q;

  always_comb begin
    push           = push_valid_i && !full;
    pop            = pop_valid_o && pop_ready_i;
    ram_we         = push && !flush_i;
    wr_ptr_d       = wr_ptr_q + {{address_width{1'b0}}, push};
    rd_ptr_d       = rd_ptr_q + {{address_width{1'b0}}, pop};
    overflow_d     = overflow_q || (push_valid_i && full);
    // Flush wins over any push/pop presented in the same cycle.
    if (flush_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      overflow_d = FALSE;
    end
    level_d        = wr_ptr_d - rd_ptr_d;
    almost_full_d  = (level_d >= AF_LVL);
    almost_empty_d = (level_d <= AE_LVL);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      overflow_q     <= FALSE;
      almost_full_q  <= FALSE;
      almost_empty_q <= TRUE;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      overflow_q     <= overflow_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
    end
  end

  // Reading at the next-cycle pointer keeps the RAM's registered address
  // equal to rd_ptr, so pop_data_o always shows the current head.
  lm32_ram #(
    .data_width    (data_width),
    .address_width (address_width)
  ) u_ram (
    .read_clk      (clk_i),
    .write_clk     (clk_i),
    .reset         (rst_i),
    .enable_read   (TRUE),
    .read_address  (rd_ptr_d[address_width-1:0]),
    .enable_write  (ram_we),
    .write_address (wr_ptr_q[address_width-1:0]),
    .write_data    (push_data_i),
    .write_enable  (ram_we),
    .read_data     (pop_data_o)
  );

endmodule

// File: tb/tb_lm32_ram_fifo.sv
// Directed bench for lm32_ram_fifo: vector table for fill/overflow/drain/flush,
// then hand-written sequences for pass-through, streaming, flush priority and async reset.
module tb_lm32_ram_fifo;

  localparam int DW = 32;
  localparam int AW = 4;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          flush_i;
  logic          push_valid_i;
  logic          push_ready_o;
  logic [DW-1:0] push_data_i;
  logic          pop_valid_o;
  logic          pop_ready_i;
  logic [DW-1:0] pop_data_o;
  logic [AW:0]   level_o;
  logic          almost_full_o;
  logic          almost_empty_o;
  logic          overflow_o;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic          push_valid;
    logic [DW-1:0] push_data;
    logic          pop_ready;
    logic          flush;
    logic          exp_valid;
    logic [DW-1:0] exp_data;
    logic [AW:0]   exp_level;
    logic          exp_pready;
    logic          exp_af;
    logic          exp_ae;
    logic          exp_ovf;
  } vec_t;

  vec_t vecs[$];

  lm32_ram_fifo #(
    .data_width         (DW),
    .address_width      (AW),
    .almost_full_level  (12),
    .almost_empty_level (2)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .flush_i        (flush_i),
    .push_valid_i   (push_valid_i),
    .push_ready_o   (push_ready_o),
    .push_data_i    (push_data_i),
    .pop_valid_o    (pop_valid_o),
    .pop_ready_i    (pop_ready_i),
    .pop_data_o     (pop_data_o),
    .level_o        (level_o),
    .almost_full_o  (almost_full_o),
    .almost_empty_o (almost_empty_o),
    .overflow_o     (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic pv, input logic [DW-1:0] pd, input logic pr, input logic fl);
    push_valid_i = pv;
    push_data_i  = pd;
    pop_ready_i  = pr;
    flush_i      = fl;
  endtask

  // Inputs are driven just after a falling edge; outputs checked at the next one.
  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_level"}, DW'(level_o), 0);
    check({tag, "_pop_valid"}, DW'(pop_valid_o), 0);
    check({tag, "_push_ready"}, DW'(push_ready_o), 1);
    check({tag, "_almost_full"}, DW'(almost_full_o), 0);
    check({tag, "_almost_empty"}, DW'(almost_empty_o), 1);
    check({tag, "_overflow"}, DW'(overflow_o), 0);
  endtask

  function automatic void add(input logic pv, input logic [DW-1:0] pd, input logic pr,
                              input logic fl, input logic ev, input logic [DW-1:0] ed,
                              input logic [AW:0] el, input logic ep, input logic eaf,
                              input logic eae, input logic eov);
    vec_t v;
    v.push_valid = pv; v.push_data = pd; v.pop_ready = pr; v.flush = fl;
    v.exp_valid = ev; v.exp_data = ed; v.exp_level = el; v.exp_pready = ep;
    v.exp_af = eaf; v.exp_ae = eae; v.exp_ovf = eov;
    vecs.push_back(v);
  endfunction

  initial begin
    rst_i = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    check_reset_values("reset");

    // Fill 0x1..0x10: head stays 0x1, ready drops once 16 words are held.
    for (int i = 0; i < 16; i++) begin
      add(1'b1, DW'(i + 1), 1'b0, 1'b0, 1'b1, 32'h1, (AW+1)'(i + 1),
          (i + 1 < 16), (i + 1 >= 12), (i + 1 <= 2), 1'b0);
    end
    // Push into a full FIFO is refused and latches overflow.
    add(1'b1, 32'hDEAD, 1'b0, 1'b0, 1'b1, 32'h1, 5'd16, 1'b0, 1'b1, 1'b0, 1'b1);
    // Drain: after pop k the head is k+2 and level is 15-k.
    for (int k = 0; k < 16; k++) begin
      add(1'b0, '0, 1'b1, 1'b0, (15 - k > 0), DW'(k + 2), (AW+1)'(15 - k),
          1'b1, (15 - k >= 12), (15 - k <= 2), 1'b1);
    end
    add(1'b0, '0, 1'b0, 1'b1, 1'b0, '0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].push_valid, vecs[i].push_data, vecs[i].pop_ready, vecs[i].flush);
      step();
      check($sformatf("vec%0d_pop_valid", i), DW'(pop_valid_o), DW'(vecs[i].exp_valid));
      if (vecs[i].exp_valid)
        check($sformatf("vec%0d_pop_data", i), pop_data_o, vecs[i].exp_data);
      check($sformatf("vec%0d_level", i), DW'(level_o), DW'(vecs[i].exp_level));
      check($sformatf("vec%0d_push_ready", i), DW'(push_ready_o), DW'(vecs[i].exp_pready));
      check($sformatf("vec%0d_almost_full", i), DW'(almost_full_o), DW'(vecs[i].exp_af));
      check($sformatf("vec%0d_almost_empty", i), DW'(almost_empty_o), DW'(vecs[i].exp_ae));
      check($sformatf("vec%0d_overflow", i), DW'(overflow_o), DW'(vecs[i].exp_ovf));
    end

    // Empty pass-through: no bypass, word appears one cycle later.
    drive(1'b1, 32'hA5, 1'b1, 1'b0);
    check("pass_no_bypass", DW'(pop_valid_o), 0);
    step();
    check("pass_valid", DW'(pop_valid_o), 1);
    check("pass_data", pop_data_o, 32'hA5);
    check("pass_level", DW'(level_o), 1);
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    check("pass_drained_level", DW'(level_o), 0);
    check("pass_drained_valid", DW'(pop_valid_o), 0);

    // Streaming at level 1 across two address wraps.
    drive(1'b1, 32'h100, 1'b0, 1'b0);
    step();
    for (int n = 0; n < 40; n++) begin
      drive(1'b1, DW'(32'h101 + n), 1'b1, 1'b0);
      check($sformatf("stream%0d_valid", n), DW'(pop_valid_o), 1);
      check($sformatf("stream%0d_data", n), pop_data_o, DW'(32'h100 + n));
      step();
      check($sformatf("stream%0d_level", n), DW'(level_o), 1);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    check("stream_last_data", pop_data_o, 32'h128);
    step();
    check("stream_end_level", DW'(level_o), 0);

    // Flush priority at level 5 with push and pop also active.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, DW'(32'h200 + i), 1'b0, 1'b0);
      step();
    end
    check("fpri_level5", DW'(level_o), 5);
    check("fpri_head", pop_data_o, 32'h200);
    drive(1'b1, 32'h2FF, 1'b1, 1'b1);
    step();
    drive(1'b0, '0, 1'b0, 1'b0);
    check("fpri_level", DW'(level_o), 0);
    check("fpri_pop_valid", DW'(pop_valid_o), 0);
    check("fpri_almost_empty", DW'(almost_empty_o), 1);
    check("fpri_almost_full", DW'(almost_full_o), 0);

    // Async reset from a full, overflowed state, between clock edges.
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, DW'(32'h300 + i), 1'b0, 1'b0);
      step();
    end
    check("ar_pre_level", DW'(level_o), 16);
    check("ar_pre_overflow", DW'(overflow_o), 1);
    check("ar_pre_almost_full", DW'(almost_full_o), 1);
    drive(1'b0, '0, 1'b0, 1'b0);
    #2;
    rst_i = 1'b1;
    #1;
    check_reset_values("async_reset");
    @(negedge clk_i);
    rst_i = 1'b0;
    drive(1'b1, 32'h5A5A, 1'b0, 1'b0);
    step();
    drive(1'b0, '0, 1'b0, 1'b0);
    check("ar_post_valid", DW'(pop_valid_o), 1);
    check("ar_post_data", pop_data_o, 32'h5A5A);
    check("ar_post_level", DW'(level_o), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
